// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, STATUS bit positions, FSM encodings
// and the divisor clamp used by both serial engines.
package uart_pkg;
    localparam logic [1:0] REG_RXDATA  = 2'd0;
    localparam logic [1:0] REG_TXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_TX_EMPTY  = 2;
    localparam int ST_RX_NEMPTY = 3;
    localparam int ST_RX_FULL   = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_TX_OVF    = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    // A divisor below 2 would leave no room for the RX half-bit wait.
    function automatic logic [15:0] effDivisor(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction
endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both UART directions. Push and pop in the same cycle
// are accepted when full; a pop of an empty FIFO is ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic             doPush, doPop;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end
endmodule

// File: rtl/uart_port.sv
// Memory-mapped UART: 16-word bus window, TX/RX FIFOs, programmable divisor,
// sticky error flags and an RX interrupt.
module uart_port
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3FFFFFF0,
    parameter int          FIFO_DEPTH = 16,
    parameter int          DIV_RESET  = 54,
    parameter int          STOP_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    inout  wire  [31:0] data,
    input  logic        request,
    input  logic        r_w,
    output logic        ready_out,
    input  logic        RxD,
    output logic        TxD,
    output logic        TxD_ready,
    output logic        rx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          selected, selQ, access, rdAccess, wrAccess, stClr;
    logic [1:0]    regSel;
    logic [31:0]   readData;
    logic [15:0]   divReg;
    logic [7:0]    status;
    logic          txOvf, frameErr, rxOvr;

    txState_t      txState, txNext;
    logic [15:0]   txDiv, txCnt;
    logic [2:0]    txBit;
    logic          txStop, txLoad, txBitEnd, txWr;
    logic [7:0]    txShift, txHead;
    logic          txFull, txEmpty;
    logic [CW-1:0] txCount;

    rxState_t      rxState, rxNext;
    logic [15:0]   rxDiv, rxCnt;
    logic [2:0]    rxBit;
    logic [7:0]    rxShift, rxHead;
    logic          rxS1, rxS2, rxPrev, rxFall, rxHalfEnd, rxBitEnd;
    logic          rxPush, rxFerr, rxPop, rxFull, rxEmpty;
    logic [CW-1:0] rxCount;

    assign selected = request && ({1'b0, address} >= {1'b0, BASE_ADDR})
                              && ({1'b0, address} <= {1'b0, BASE_ADDR} + 33'd15);
    assign regSel   = address[1:0];
    assign access   = selected & ~selQ;
    assign rdAccess = access & ~r_w;
    assign wrAccess = access & r_w;
    assign stClr    = rdAccess && (regSel == REG_STATUS);
    assign rxPop    = rdAccess && (regSel == REG_RXDATA);
    assign txWr     = wrAccess && (regSel == REG_TXDATA);

    assign ready_out = selected ? 1'b1 : 1'bz;
    assign data      = (selected && !r_w) ? readData : 32'bz;
    assign TxD_ready = ~txFull;
    assign rx_irq    = ~rxEmpty | txOvf | frameErr | rxOvr;

    always_comb begin
        status               = '0;
        status[ST_TX_BUSY]   = (txState != TX_IDLE);
        status[ST_TX_FULL]   = txFull;
        status[ST_TX_EMPTY]  = (txCount == '0);
        status[ST_RX_NEMPTY] = ~rxEmpty;
        status[ST_RX_FULL]   = (rxCount == CW'(FIFO_DEPTH));
        status[ST_RX_OVR]    = rxOvr;
        status[ST_FRAME_ERR] = frameErr;
        status[ST_TX_OVF]    = txOvf;
    end

    always_comb begin
        readData = '0;
        case (regSel)
            REG_RXDATA:  if (!rxEmpty) readData = {24'b0, rxHead};
            REG_STATUS:  readData = {24'b0, status};
            REG_DIVISOR: readData = {16'b0, divReg};
            default:     readData = '0;
        endcase
    end

    // Error sets win over a simultaneous STATUS-read clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            selQ     <= 1'b0;
            divReg   <= 16'(DIV_RESET);
            txOvf    <= 1'b0;
            frameErr <= 1'b0;
            rxOvr    <= 1'b0;
        end else begin
            selQ <= selected;
            if (wrAccess && (regSel == REG_DIVISOR)) divReg <= data[15:0];
            txOvf    <= (txOvf & ~stClr) | (txWr & txFull & ~txLoad);
            frameErr <= (frameErr & ~stClr) | rxFerr;
            rxOvr    <= (rxOvr & ~stClr) | (rxPush & rxFull & ~rxPop);
        end
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) txFifo (
        .clk(clk), .rst_n(rst_n), .push(txWr), .pop(txLoad), .din(data[7:0]),
        .dout(txHead), .full(txFull), .empty(txEmpty), .count(txCount)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rxFifo (
        .clk(clk), .rst_n(rst_n), .push(rxPush), .pop(rxPop), .din(rxShift),
        .dout(rxHead), .full(rxFull), .empty(rxEmpty), .count(rxCount)
    );

    assign txBitEnd = (txCnt == txDiv - 16'd1);

    always_comb begin
        txNext = txState;
        txLoad = 1'b0;
        case (txState)
            TX_IDLE:  if (!txEmpty) begin txNext = TX_START; txLoad = 1'b1; end
            TX_START: if (txBitEnd) txNext = TX_DATA;
            TX_DATA:  if (txBitEnd && txBit == 3'd7) txNext = TX_STOP;
            TX_STOP:  if (txBitEnd && txStop == 1'(STOP_BITS - 1)) begin
                if (!txEmpty) begin txNext = TX_START; txLoad = 1'b1; end
                else txNext = TX_IDLE;
            end
            default:  txNext = TX_IDLE;
        endcase
    end

    always_comb begin
        case (txState)
            TX_START: TxD = 1'b0;
            TX_DATA:  TxD = txShift[0];
            default:  TxD = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) txState <= TX_IDLE;
        else        txState <= txNext;
    end

    // The divisor is latched per frame so a DIVISOR write never stretches a bit in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txCnt   <= '0;
            txDiv   <= 16'd2;
            txBit   <= '0;
            txStop  <= 1'b0;
            txShift <= '0;
        end else if (txLoad) begin
            txCnt   <= '0;
            txDiv   <= effDivisor(divReg);
            txBit   <= '0;
            txStop  <= 1'b0;
            txShift <= txHead;
        end else if (txState != TX_IDLE) begin
            if (txBitEnd) begin
                txCnt <= '0;
                if (txState == TX_DATA) begin
                    txBit   <= txBit + 3'd1;
                    txShift <= txShift >> 1;
                end
                if (txState == TX_STOP) txStop <= txStop + 1'b1;
            end else begin
                txCnt <= txCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rxS1, rxS2, rxPrev} <= 3'b111;
        else        {rxS1, rxS2, rxPrev} <= {RxD, rxS1, rxS2};
    end

    assign rxFall    = rxPrev & ~rxS2;
    assign rxHalfEnd = (rxCnt == (rxDiv >> 1) - 16'd1);
    assign rxBitEnd  = (rxCnt == rxDiv - 16'd1);

    always_comb begin
        rxNext = rxState;
        rxPush = 1'b0;
        rxFerr = 1'b0;
        case (rxState)
            RX_IDLE:  if (rxFall) rxNext = RX_START;
            RX_START: if (rxHalfEnd) rxNext = rxS2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rxBitEnd && rxBit == 3'd7) rxNext = RX_STOP;
            RX_STOP:  if (rxBitEnd) begin
                rxNext = RX_IDLE;
                rxPush = rxS2;
                rxFerr = ~rxS2;
            end
            default:  rxNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxState <= RX_IDLE;
        else        rxState <= rxNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxCnt   <= '0;
            rxDiv   <= 16'd2;
            rxBit   <= '0;
            rxShift <= '0;
        end else begin
            case (rxState)
                RX_IDLE: begin
                    rxCnt <= '0;
                    rxBit <= '0;
                    if (rxFall) rxDiv <= effDivisor(divReg);
                end
                RX_START: rxCnt <= rxHalfEnd ? 16'd0 : rxCnt + 16'd1;
                RX_DATA: begin
                    if (rxBitEnd) begin
                        rxCnt   <= '0;
                        rxBit   <= rxBit + 3'd1;
                        rxShift <= {rxS2, rxShift[7:1]};
                    end else begin
                        rxCnt <= rxCnt + 16'd1;
                    end
                end
                default: rxCnt <= rxCnt + 16'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_port.sv
// Directed and randomized bench for uart_port; expectations come from a queue-based
// model of the FIFOs/sticky flags and from frames composed bit by bit.
`timescale 1ns/1ps
module tb_uart_port;
    localparam logic [31:0] BASE  = 32'h3FFFFFF0;
    localparam int          DEPTH = 16;
    localparam int          DIVR  = 54;
    localparam int          SB    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] address = '0;
    logic        request = 1'b0;
    logic        r_w = 1'b0;
    logic        RxD = 1'b1;
    wire  [31:0] data;
    wire         ready_out;
    logic        TxD, TxD_ready, rx_irq;
    logic        tbDrv = 1'b0;
    logic [31:0] tbData = '0;

    int total = 0;
    int bad = 0;

    byte unsigned rxQ[$];
    bit mTxOvf = 0, mFerr = 0, mOvr = 0;

    assign data = tbDrv ? tbData : 32'bz;

    uart_port #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR), .STOP_BITS(SB)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data(data), .request(request),
        .r_w(r_w), .ready_out(ready_out), .RxD(RxD), .TxD(TxD), .TxD_ready(TxD_ready),
        .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expStatus(input logic busy, input logic tFull, input logic tEmpty);
        logic [7:0] s;
        s = {mTxOvf, mFerr, mOvr, rxQ.size() == DEPTH, rxQ.size() != 0, tEmpty, tFull, busy};
        return {24'b0, s};
    endfunction

    function automatic logic expIrq();
        return (rxQ.size() != 0) || mTxOvf || mFerr || mOvr;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        address = addr; r_w = 1'b1; request = 1'b1; tbDrv = 1'b1; tbData = val;
        @(negedge clk);
        request = 1'b0; tbDrv = 1'b0; r_w = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] val);
        @(negedge clk);
        address = addr; r_w = 1'b0; request = 1'b1;
        #1 val = data;
        @(negedge clk);
        request = 1'b0;
    endtask

    task automatic statusChk(input string tag, input logic busy, input logic tFull, input logic tEmpty);
        logic [31:0] v;
        busRead(BASE + 2, v);
        check(tag, v, expStatus(busy, tFull, tEmpty));
        mTxOvf = 0; mFerr = 0; mOvr = 0;
    endtask

    task automatic rxReadChk(input string tag);
        logic [31:0] v, e;
        busRead(BASE + 0, v);
        e = '0;
        if (rxQ.size() != 0) e = {24'b0, rxQ.pop_front()};
        check(tag, v, e);
    endtask

    // Drives one serial frame; the model receives it only if the stop bit is high.
    task automatic sendRx(input logic [7:0] b, input int div, input logic stopBit);
        @(negedge clk);
        RxD = 1'b0;
        repeat (div) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            RxD = b[k];
            repeat (div) @(negedge clk);
        end
        RxD = stopBit;
        repeat (div) @(negedge clk);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
        if (!stopBit) mFerr = 1;
        else if (rxQ.size() < DEPTH) rxQ.push_back(b);
        else mOvr = 1;
    endtask

    // Finds the start bit, then requires every bit cell to hold a constant level for
    // exactly div clocks and to match start/LSB-first data/stop bits.
    task automatic checkTx(input string tag, input logic [7:0] b, input int div,
                           input int budget, input bit immediate);
        logic [11:0] expB, obsB;
        logic        unstable, first;
        int          waited;
        expB = '1;
        expB[0] = 1'b0;
        for (int k = 0; k < 8; k++) expB[k+1] = b[k];
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (TxD !== 1'b0 && waited < budget);
        if (TxD !== 1'b0) begin
            check({tag, "_start"}, {31'b0, TxD}, 32'd0);
            return;
        end
        obsB = '1;
        unstable = 1'b0;
        first = 1'b1;
        for (int c = 0; c < 9 + SB; c++) begin
            for (int s = 0; s < div; s++) begin
                if (!(c == 0 && s == 0)) begin
                    @(posedge clk); #1;
                end
                if (s == 0) first = TxD;
                else if (TxD !== first) unstable = 1'b1;
            end
            obsB[c] = first;
        end
        check(tag, {19'b0, unstable, obsB}, {19'b0, 1'b0, expB});
        if (immediate) check({tag, "_gap"}, waited, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b, b2;
        int          d;
        logic [7:0]  txList [16];

        // reset state
        idle(3);
        check("rst_txd", {31'b0, TxD}, 32'd1);
        check("rst_txready", {31'b0, TxD_ready}, 32'd1);
        check("rst_irq", {31'b0, rx_irq}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        @(negedge clk);
        address = BASE + 3; r_w = 1'b0; request = 1'b1;
        #1;
        check("ready_out", {31'b0, ready_out}, 32'd1);
        check("rst_divisor", data, DIVR);
        @(negedge clk);
        request = 1'b0;
        statusChk("rst_status", 0, 0, 1);

        // fixed 0xA5 frame at divisor 4
        busWrite(BASE + 3, 32'd4);
        busRead(BASE + 3, v);
        check("div_rd4", v, 32'd4);
        busWrite(BASE + 1, 32'hA5);
        checkTx("tx_a5", 8'hA5, 4, 20, 0);
        idle(2);
        statusChk("tx_a5_idle", 0, 0, 1);

        // decode window edges and ignored accesses
        busWrite(BASE + 17, 32'h55);
        busWrite(BASE - 15, 32'h55);
        busWrite(BASE + 2, 32'hFF);
        busWrite(BASE + 0, 32'h77);
        idle(3);
        statusChk("ignored_writes", 0, 0, 1);
        busRead(BASE + 1, v);
        check("txdata_read", v, 32'd0);
        check("ignored_irq", {31'b0, rx_irq}, {31'b0, expIrq()});

        // divisor below 2 clamps to 2
        busWrite(BASE + 3, 32'd0);
        busRead(BASE + 3, v);
        check("div_rd0", v, 32'd0);
        b = 8'($urandom);
        busWrite(BASE + 1, {24'b0, b});
        checkTx("tx_div0", b, 2, 20, 0);
        busWrite(BASE + 3, 32'd1);
        b = 8'($urandom);
        busWrite(BASE + 5, {24'b0, b});
        checkTx("tx_div1", b, 2, 20, 0);

        // randomized TX and RX round trips
        for (int it = 0; it < 6; it++) begin
            d = $urandom_range(4, 12);
            busWrite(BASE + 3, d);
            b = 8'($urandom);
            busWrite(BASE + 1, {24'b0, b});
            checkTx($sformatf("tx_rand%0d", it), b, d, 20, 0);
            b2 = 8'($urandom);
            sendRx(b2, d, 1'b1);
            check($sformatf("rx_irq%0d", it), {31'b0, rx_irq}, {31'b0, expIrq()});
            rxReadChk($sformatf("rx_rand%0d", it));
        end

        // 0x3C at divisor 8, then empty read
        busWrite(BASE + 3, 32'd8);
        sendRx(8'h3C, 8, 1'b1);
        check("rx3c_irq", {31'b0, rx_irq}, 32'd1);
        rxReadChk("rx3c_data");
        rxReadChk("rx3c_empty");
        check("rx3c_irq_clr", {31'b0, rx_irq}, 32'd0);

        // framing error and glitch rejection
        sendRx(8'($urandom), 8, 1'b0);
        check("ferr_irq", {31'b0, rx_irq}, 32'd1);
        statusChk("ferr_status", 0, 0, 1);
        check("ferr_irq_clr", {31'b0, rx_irq}, 32'd0);
        @(negedge clk);
        RxD = 1'b0;
        idle(3);
        RxD = 1'b1;
        idle(12);
        statusChk("glitch_status", 0, 0, 1);

        // held request pops once
        b = 8'($urandom);
        b2 = 8'($urandom);
        sendRx(b, 8, 1'b1);
        sendRx(b2, 8, 1'b1);
        @(negedge clk);
        address = BASE; r_w = 1'b0; request = 1'b1;
        #1 v = data;
        idle(5);
        request = 1'b0;
        check("hold_rd_data", v, {24'b0, rxQ.pop_front()});
        statusChk("hold_rd_status", 0, 0, 1);
        rxReadChk("hold_rd_second");
        statusChk("hold_rd_empty", 0, 0, 1);

        // RX overflow at divisor 4
        busWrite(BASE + 3, 32'd4);
        for (int i = 0; i < DEPTH + 1; i++) sendRx(8'($urandom), 4, 1'b1);
        check("rxovr_irq", {31'b0, rx_irq}, {31'b0, expIrq()});
        statusChk("rxovr_status", 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) rxReadChk($sformatf("rxovr_drain%0d", i));
        check("rxovr_irq_clr", {31'b0, rx_irq}, 32'd0);

        // TX overflow while busy, then back-to-back drain at a new divisor
        busWrite(BASE + 3, 32'd100);
        busWrite(BASE + 1, 32'hFF);
        idle(2);
        for (int i = 0; i < DEPTH; i++) begin
            txList[i] = 8'($urandom);
            busWrite(BASE + 1, {24'b0, txList[i]});
        end
        check("txfull_ready", {31'b0, TxD_ready}, 32'd0);
        busWrite(BASE + 1, 32'h5A);
        mTxOvf = 1;
        check("txovf_irq", {31'b0, rx_irq}, {31'b0, expIrq()});
        statusChk("txovf_status", 1, 1, 0);
        statusChk("txovf_cleared", 1, 1, 0);
        busWrite(BASE + 3, 32'd3);
        idle(80);
        for (int i = 0; i < DEPTH; i++)
            checkTx($sformatf("tx_b2b%0d", i), txList[i], 3, (i == 0) ? 1500 : 2, i != 0);
        idle(2);
        statusChk("tx_b2b_done", 0, 0, 1);

        // reset in the middle of a frame
        busWrite(BASE + 3, 32'd6);
        busWrite(BASE + 1, 32'h00);
        busWrite(BASE + 1, 32'h00);
        idle(15);
        check("midframe_low", {31'b0, TxD}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_txd", {31'b0, TxD}, 32'd1);
        rxQ.delete();
        mTxOvf = 0; mFerr = 0; mOvr = 0;
        idle(2);
        rst_n = 1'b1;
        busRead(BASE + 3, v);
        check("midframe_divisor", v, DIVR);
        statusChk("midframe_status", 0, 0, 1);
        check("midframe_ready", {31'b0, TxD_ready}, 32'd1);
        check("midframe_irq", {31'b0, rx_irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_port.md
UART_PORT -- requirements
Module: uart_port

Interface
REQ-001 SHALL take parameter BASE_ADDR, default 32'h3FFFFFF0; first word address of the 16-word decode window.
REQ-002 SHALL take parameter FIFO_DEPTH, default 16; entries per TX and RX FIFO, power of 2, minimum 2.
REQ-003 SHALL take parameter DIV_RESET, default 54; reset value of the baud divisor (clocks per bit; 50 MHz / 921600).
REQ-004 SHALL take parameter STOP_BITS, default 2; TX stop bits, 1 or 2.
REQ-005 Ports: clk  in  1  system clock; all logic on rising edge.
REQ-006 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Ports: address  in  32  bus word address.
REQ-008 Ports: data  inout  32  bus data; driven only on selected read, else high-Z.
REQ-009 Ports: request  in  1  bus cycle valid.
REQ-010 Ports: r_w  in  1  1 = write, 0 = read.
REQ-011 Ports: ready_out  out  1  1 when selected, else high-Z.
REQ-012 Ports: RxD  in  1  serial input, asynchronous, idle high.
REQ-013 Ports: TxD  out  1  serial output, idle high.
REQ-014 Ports: TxD_ready  out  1  TX FIFO not full.
REQ-015 Ports: rx_irq  out  1  RX FIFO not empty, or any sticky error bit set.

Function
REQ-016 selected SHALL be request & BASE_ADDR <= address <= BASE_ADDR+15 (unsigned); ready_out = 1 in the same cycle (zero wait states).
REQ-017 Register map SHALL use address[1:0]: 0 RXDATA (R), 1 TXDATA (W), 2 STATUS (R), 3 DIVISOR (R/W, bits[15:0]).
REQ-018 A bus access SHALL take effect once, on the first clock edge of a selected cycle (selected & ~sel_q, sel_q = selected registered); holding request SHALL NOT repeat pops or pushes.
REQ-019 RXDATA read SHALL return {24'b0, head byte} combinationally and pop on the access edge; read when empty returns 0 and does not pop.
REQ-020 TXDATA write SHALL push data[7:0]; write when full SHALL be dropped and set sticky tx_ovf.
REQ-021 STATUS SHALL read {24'b0, tx_ovf, frame_err, rx_ovr, rx_full, rx_nempty, tx_empty, tx_full, tx_busy}, bits 7..0; the access edge clears tx_ovf, frame_err and rx_ovr.
REQ-022 DIVISOR write SHALL load data[15:0]; effective divisor = max(DIVISOR, 2); a new value applies from the next frame start.
REQ-023 Writes to RXDATA or STATUS and reads of TXDATA SHALL be ignored (reads return 0).
REQ-024 TX FSM SHALL use IDLE -> START -> DATA(8 bits, LSB first) -> STOP(STOP_BITS) -> IDLE; each bit is exactly divisor clocks.
REQ-025 TX SHALL pop the FIFO on leaving IDLE; after STOP it SHALL go directly to START if the FIFO is non-empty, giving no idle gap.
REQ-026 tx_busy SHALL be 1 in any TX state other than IDLE.
REQ-027 RxD SHALL pass through a 2-flop synchroniser before use.
REQ-028 RX FSM SHALL use IDLE -> START -> DATA -> STOP; it leaves IDLE on a synchronised falling edge.
REQ-029 In START, RX SHALL wait divisor/2 clocks and recheck the line: if high, it returns to IDLE as a glitch; if low, it samples each subsequent bit every divisor clocks.
REQ-030 At STOP, a low sample SHALL set frame_err and discard the byte; a high sample SHALL push the byte.
REQ-031 A push into a full RX FIFO SHALL drop the byte and set rx_ovr.
REQ-032 FIFO SHALL accept push and pop in the same cycle when full, and also when empty (pass-through not required: the pop of an empty FIFO is ignored).
REQ-033 Count width SHALL be $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 On rst_n low, all state SHALL clear asynchronously: FIFOs empty, FSMs IDLE, sticky bits 0, DIVISOR = DIV_RESET, TxD = 1, TxD_ready = 1, rx_irq = 0.
REQ-035 Reset mid-frame SHALL abort the frame immediately with TxD = 1; partial RX bytes SHALL be discarded.

Structure
REQ-036 Shared package uart_pkg SHALL hold the register offsets, the STATUS bit indices, and the TX/RX state encodings.
REQ-037 A single sub-module uart_fifo (params WIDTH, DEPTH; push, pop, full, empty, count) SHALL be instantiated twice.

Verification
REQ-038 DIVISOR = 4, write 8'hA5: TxD low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 8 clocks; tx_busy drops afterwards.
REQ-039 Write 17 bytes back-to-back, FIFO_DEPTH = 16, TX busy: 17th dropped, STATUS bit7 = 1, then cleared on STATUS read.
REQ-040 Drive frame 8'h3C on RxD at DIVISOR = 8: rx_irq = 1; RXDATA reads 32'h3C; next read returns 0 and rx_irq = 0.
REQ-041 Frame with low stop bit: frame_err = 1, RX FIFO stays empty; a 3-clock low glitch at DIVISOR = 8 produces no push.
REQ-042 Hold request + read RXDATA for 5 cycles with 2 bytes queued: only one pop, count = 1.
REQ-043 Assert rst_n low mid-TX frame: TxD = 1 within the same cycle, DIVISOR reads DIV_RESET, STATUS reads 32'h04.
